bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Shares one downstream memory bus between the core's instruction-fetch master (port 0) and data load/store master (port 1).
- Sits between the core's two bus_master instances and the single memory/MMIO bus.
- Allows exactly one outstanding transaction.
- Provides fixed priority with anti-starvation, grant locking under backpressure, and a response timeout that returns a bus error.

Parameters:
- DATA_PRIO, 1: port that wins a simultaneous request (0 = inst, 1 = data).
- MAX_CONSEC, 4: maximum consecutive grants to the priority port while the other port waits; range 1..15.
- TIMEOUT, 255: cycles in WAIT without m_valid before an error is forced; 8-bit counter, 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s0_en, s1_en  in  1 each  request valid
- s0_we, s1_we  in  1 each  write enable
- s0_addr, s1_addr  in  30 each  word address [31:2]
- s0_wdata, s1_wdata  in  32 each  write data
- s0_mask, s1_mask  in  4 each  byte write mask
- s0_stall, s1_stall  out  1 each  request not accepted this cycle
- s0_valid, s1_valid  out  1 each  response valid (one-cycle pulse)
- s0_rdata, s1_rdata  out  32 each  read data
- s0_err, s1_err  out  1 each  error, qualified by sN_valid
- m_en  out  1  downstream request
- m_we  out  1  downstream write enable
- m_addr  out  30  downstream word address
- m_wdata  out  32  downstream write data
- m_mask  out  4  downstream byte mask
- m_stall  in  1  downstream cannot accept request
- m_valid  in  1  downstream response valid
- m_rdata  in  32  downstream read data
- m_err  in  1  downstream error
- busy  out  1  state is WAIT
- owner  out  1  port owning the current or locked transaction

Behaviour:
- Reset: clk is the only clock; rst is asynchronous and active-high.
  - Forces state IDLE; clears lock, owner, starvation count and timeout count.
  - While rst is high: m_en, sN_valid, sN_err, sN_stall and busy = 0; rdata = 0.
- States: IDLE and WAIT.
- IDLE arbitration:
  - Winner = lock owner if lock is set.
  - Otherwise the sole requester.
  - Otherwise, on a tie: the priority port, unless starve_cnt == MAX_CONSEC, in which case the non-priority port.
- IDLE drive: m_* is driven combinationally from the winner; m_en = winner's en.
- IDLE stall rules:
  - Winner's sN_stall = m_stall; loser's sN_stall = its en.
- IDLE accept and lock:
  - Accepted when m_en & ~m_stall: latch owner, go to WAIT, clear lock.
  - If m_stall = 1: set lock to the winner. m_* must stay on that port until accepted.
  - If the locked port drops en, clear lock next cycle; the request is abandoned.
- Starvation count:
  - On accept of the priority port while the other port's en = 1: starve_cnt++ (saturating).
  - On accept of the non-priority port, or when the other port's en = 0: starve_cnt = 0.
- WAIT drive: m_en = 0; sN_stall = sN_en for both ports; tcnt increments each cycle.
- WAIT exit on m_valid:
  - Same cycle: s[owner]_valid = 1, s[owner]_rdata = m_rdata, s[owner]_err = m_err.
  - Next state IDLE; tcnt = 0.
- WAIT exit on timeout: if TIMEOUT != 0 and tcnt == TIMEOUT-1 without m_valid:
  - s[owner]_valid = 1, s[owner]_err = 1, s[owner]_rdata = 0; go to IDLE.
  - A late m_valid then arrives in IDLE and is discarded.
- Discarded responses: m_valid in IDLE is never forwarded. This includes a response to a transaction in flight when rst was asserted.
- Non-owner outputs: valid, err = 0; rdata = 0.
- Throughput and latency:
  - Minimum 2 cycles per transaction (accept cycle, response cycle); back-to-back issue is not permitted.
  - Zero added request latency in IDLE; zero added response latency (combinational return path).
- Simultaneous m_valid and timeout in the same cycle: m_valid wins; data and err are forwarded from the bus.

Test Plan:
- Reset → outputs: rst pulse mid-WAIT with owner = 1 → within the same cycle m_en = 0, busy = 0; the following m_valid = 1 with rdata 0xDEADBEEF is not forwarded to either port.
- Data-priority tie: s0_en = s1_en = 1, m_stall = 0, DATA_PRIO = 1 → m_addr = s1_addr, s0_stall = 1, s1_stall = 0; response 0x12345678 appears on s1_rdata with s1_valid = 1 only.
- Anti-starvation: both ports request continuously, MAX_CONSEC = 4 → grant sequence 1,1,1,1,0,1,1,1,1,0.
- Lock under backpressure: s0 alone requests with m_stall = 1 for 3 cycles; s1 raises en on cycle 2 → m_addr stays s0_addr for all 3 cycles; s0 is accepted on cycle 4; s1_stall = 1 throughout.
- Timeout: TIMEOUT = 8, grant s0, m_valid held 0 → s0_valid = 1, s0_err = 1 exactly 8 cycles after accept; m_valid on cycle 10 is discarded.
- Write path: s1_we = 1, s1_mask = 4'b0011, s1_wdata = 0x0000BEEF, s1_addr = 0x100 → m_we = 1, m_mask = 4'b0011, m_addr = 0x100; s1_valid = 1 on the m_valid cycle.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter
// Shares a single downstream memory/MMIO bus between the instruction-fetch
// master (port 0) and the data load/store master (port 1). Only one
// transaction can be outstanding at a time.
//
// Arbitration uses a fixed priority with an anti-starvation counter. A
// granted-but-stalled request stays locked onto the bus until it is
// accepted. If no response arrives within the timeout, the arbiter returns
// a bus error to the owning port.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   sN_en/we/addr/...   upstream request from master N (N = 0 inst, 1 data)
//   sN_stall            request not accepted this cycle
//   sN_valid/rdata/err  one-cycle response pulse to master N
//   m_en/we/addr/...    downstream request
//   m_stall             downstream cannot accept a request
//   m_valid/rdata/err   downstream response
//   busy                a transaction is outstanding
//   owner               port owning the current or locked transaction
module bus_arbiter #(
  parameter int DATA_PRIO  = 1,
  parameter int MAX_CONSEC = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s0_en,
  input  logic        s0_we,
  input  logic [29:0] s0_addr,
  input  logic [31:0] s0_wdata,
  input  logic [3:0]  s0_mask,
  output logic        s0_stall,
  output logic        s0_valid,
  output logic [31:0] s0_rdata,
  output logic        s0_err,
  input  logic        s1_en,
  input  logic        s1_we,
  input  logic [29:0] s1_addr,
  input  logic [31:0] s1_wdata,
  input  logic [3:0]  s1_mask,
  output logic        s1_stall,
  output logic        s1_valid,
  output logic [31:0] s1_rdata,
  output logic        s1_err,
  output logic        m_en,
  output logic        m_we,
  output logic [29:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_mask,
  input  logic        m_stall,
  input  logic        m_valid,
  input  logic [31:0] m_rdata,
  input  logic        m_err,
  output logic        busy,
  output logic        owner
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic       PRIO       = (DATA_PRIO != 0);
  localparam logic [3:0] MAX_C      = 4'(MAX_CONSEC);
  localparam logic       TO_EN      = (TIMEOUT != 0);
  localparam logic [7:0] TLAST      = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        lock_q, lock_d;
  logic [3:0]  starve_q, starve_d;
  logic [7:0]  tcnt_q, tcnt_d;

  logic        win;
  logic        win_en;
  logic        other_en;
  logic        timeout;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  // State registers. owner_q records the port of the accepted transaction.
  // While a stalled request is locked, owner_q also holds the locked port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      lock_q   <= 1'b0;
      starve_q <= 4'd0;
      tcnt_q   <= 4'd0 == 4'd0 ? 8'd0 : 8'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      lock_q   <= lock_d;
      starve_q <= starve_d;
      tcnt_q   <= tcnt_d;
    end
  end

  // Arbitration, request steering, timeout and response routing.
  // Reset forces every handshake output low. This holds combinationally,
  // even in the middle of a cycle.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    lock_d    = lock_q;
    starve_d  = starve_q;
    tcnt_d    = tcnt_q;
    m_en      = 1'b0;
    s0_stall  = 1'b0;
    s1_stall  = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = 32'd0;
    timeout   = 1'b0;

    // The locked port always wins. A tie normally goes to the priority
    // port. Once the priority port has won MAX_CONSEC times in a row while
    // the other port waited, the other port gets one grant.
    if (lock_q) begin
      win = owner_q;
    end else if (s0_en && !s1_en) begin
      win = 1'b0;
    end else if (s1_en && !s0_en) begin
      win = 1'b1;
    end else if (s0_en && s1_en) begin
      win = (starve_q == MAX_C) ? ~PRIO : PRIO;
    end else begin
      win = PRIO;
    end

    win_en   = win ? s1_en : s0_en;
    other_en = win ? s0_en : s1_en;

    m_we    = win ? s1_we    : s0_we;
    m_addr  = win ? s1_addr  : s0_addr;
    m_wdata = win ? s1_wdata : s0_wdata;
    m_mask  = win ? s1_mask  : s0_mask;

    case (state_q)
      ST_IDLE: begin
        m_en     = win_en;
        s0_stall = win ? s0_en : (s0_en & m_stall);
        s1_stall = win ? (s1_en & m_stall) : s1_en;
        if (win_en && !m_stall) begin
          state_d = ST_WAIT;
          owner_d = win;
          lock_d  = 1'b0;
          tcnt_d  = 8'd0;
          if (win == PRIO && other_en) begin
            starve_d = (starve_q == MAX_C) ? starve_q : starve_q + 4'd1;
          end else begin
            starve_d = 4'd0;
          end
        end else if (win_en && m_stall) begin
          lock_d  = 1'b1;
          owner_d = win;
        end else if (lock_q) begin
          // The locked master withdrew its request, so the request is abandoned.
          lock_d = 1'b0;
        end
      end
      ST_WAIT: begin
        s0_stall = s0_en;
        s1_stall = s1_en;
        tcnt_d   = tcnt_q + 8'd1;
        timeout  = TO_EN && (tcnt_q == TLAST);
        // A real response takes precedence over a timeout in the same cycle.
        if (m_valid || timeout) begin
          state_d   = ST_IDLE;
          tcnt_d    = 8'd0;
          rsp_valid = 1'b1;
          rsp_err   = m_valid ? m_err : 1'b1;
          rsp_rdata = m_valid ? m_rdata : 32'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    s0_valid = rsp_valid & ~owner_q;
    s0_err   = rsp_err & ~owner_q;
    s0_rdata = owner_q ? 32'd0 : rsp_rdata;
    s1_valid = rsp_valid & owner_q;
    s1_err   = rsp_err & owner_q;
    s1_rdata = owner_q ? rsp_rdata : 32'd0;

    if (rst) begin
      m_en     = 1'b0;
      s0_stall = 1'b0;
      s1_stall = 1'b0;
      s0_valid = 1'b0;
      s1_valid = 1'b0;
      s0_err   = 1'b0;
      s1_err   = 1'b0;
      s0_rdata = 32'd0;
      s1_rdata = 32'd0;
    end
  end

  assign busy  = (state_q == ST_WAIT) & ~rst;
  assign owner = owner_q;

endmodule
